w5_loader: RTL

- Fills the 16 weight banks (16 entries x signed 8-bit each) that the w5 layer engine reads.
- Accepts a byte stream over a valid/ready handshake and writes it address-major, bank-minor into the banks.
- Asserts finish once every entry is written, so the controller can then issue start to the w5 engine.
- Sits between the host/DMA weight stream and the bank write ports.

---
 rtl/w5_pkg.sv | 27 ++
 rtl/w5_loader.sv | 104 ++++++++++
 2 files changed

// File: rtl/w5_pkg.sv
// w5_pkg: shared constants, types and the loader state encoding used by the
// w5 weight loader and the w5 layer engine.
//   NBANK   - number of weight banks (one per parallel lane)
//   DEPTH   - entries per bank
//   AWIDTH  - bank address width, log2(DEPTH)
//   DWIDTH  - weight width (two's complement)
//   NWEIGHT - total entries across all banks
package w5_pkg;

  localparam int NBANK   = 16;
  localparam int DEPTH   = 16;
  localparam int AWIDTH  = 4;
  localparam int DWIDTH  = 8;
  localparam int NWEIGHT = NBANK * DEPTH;
  localparam int BSEL_W  = $clog2(NBANK);
  localparam int CWIDTH  = $clog2(NWEIGHT);

  typedef logic signed [DWIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/w5_loader.sv
// w5_loader: fills the 16 w5 weight banks from a byte stream.
// Bytes arrive on a valid/ready handshake and are written address-major,
// bank-minor: byte k goes to bank k[3:0], address k[7:4]. Each bank write is
// registered, so it appears on the write ports one cycle after its handshake.
//
// Ports:
//   clk      - clock, rising edge
//   xrst     - synchronous active-low reset
//   start    - one-cycle load request, honoured only in IDLE
//   in_valid - in_data valid this cycle
//   in_data  - signed weight byte
//   in_ready - loader accepts in_data this cycle (high only in LOAD)
//   w_we     - one-hot bank write enable
//   w_waddr  - write address shared by all banks
//   w_wdata  - write data shared by all banks
//   busy     - high from the start-accept cycle until finish
//   finish   - one-cycle pulse once all entries are written
//   csum     - (only with W5_LOADER_CSUM_EN) 16-bit wrapping sum of the
//              sign-extended accepted bytes; stable from finish until the
//              next start
//
// Build option: define W5_LOADER_CSUM_EN to add the csum output and its
// accumulator. The default build has neither.
module w5_loader
  import w5_pkg::*;
(
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DWIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic [NBANK-1:0]         w_we,
  output logic [AWIDTH-1:0]        w_waddr,
  output logic signed [DWIDTH-1:0] w_wdata,
  output logic                     busy,
  output logic                     finish
`ifdef W5_LOADER_CSUM_EN
  ,
  output logic [15:0]              csum
`endif
);

  state_t            state;
  state_t            state_nx;
  logic [CWIDTH-1:0] cnt;
  logic              hs;
  logic              start_acc;

  assign hs        = in_valid & in_ready;
  assign start_acc = (state == IDLE) & start;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == CWIDTH'(NWEIGHT - 1)) state_nx = FLUSH;
      end
      FLUSH:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake stage -> bank write port stage. busy follows the next state so
  // it drops on the same edge that raises finish; finish is the registered
  // image of DONE, one cycle after the final write has left the ports.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state   <= IDLE;
      cnt     <= '0;
      w_we    <= '0;
      w_waddr <= '0;
      w_wdata <= '0;
      busy    <= 1'b0;
      finish  <= 1'b0;
    end else begin
      state  <= state_nx;
      busy   <= (state_nx != IDLE);
      finish <= (state == DONE);
      w_we   <= hs ? (NBANK'(1) << cnt[BSEL_W-1:0]) : '0;
      if (hs) begin
        w_waddr <= cnt[CWIDTH-1:BSEL_W];
        w_wdata <= in_data;
        cnt     <= cnt + 1'b1;
      end
      if (start_acc) cnt <= '0;
    end
  end

`ifdef W5_LOADER_CSUM_EN
  always_ff @(posedge clk) begin
    if (!xrst || start_acc) begin
      csum <= '0;
    end else if (hs) begin
      csum <= csum + {{(16-DWIDTH){in_data[DWIDTH-1]}}, in_data};
    end
  end
`endif

endmodule
